// File: rtl/d_fork_pkg.sv
// Shared constants and types for the eager fork that sits behind each CGRA cell FIFO.
// The lane mask type is sized for the widest legal fork so every instance can share it.
package d_fork_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_OUT_DEF    = 4;
  localparam int NUM_OUT_MAX    = 8;

  typedef logic [NUM_OUT_MAX-1:0] lane_mask_t;

endpackage : d_fork_pkg

// File: rtl/d_fork_lane.sv
// One output lane of the eager fork: a single "served" flop that remembers whether
// this consumer already took the token currently presented upstream.
module d_fork_lane
  import d_fork_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic mask_i,
  input  logic din_v,
  input  logic dout_r_i,
  input  logic fire,
  output logic dout_v_i,
  output logic ok_i
);

  logic done_q;
  logic done_d;

  // Valid never looks at the consumer's ready, so no ready->valid path exists.
  assign dout_v_i = din_v & mask_i & ~done_q;
  assign ok_i     = ~mask_i | done_q | dout_r_i;

  always_comb begin
    done_d = done_q;
    if (fire) begin
      done_d = 1'b0;
    end else if (dout_v_i & dout_r_i) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule : d_fork_lane

// File: rtl/d_eager_fork.sv
// Elastic eager fork: broadcasts one valid/ready token to NUM_OUT consumers and only
// releases it upstream once every enabled lane has taken it. Payload passes through.
module d_eager_fork
  import d_fork_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_OUT    = NUM_OUT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_OUT-1:0]    io_mask,
  input  logic [DATA_WIDTH-1:0] io_din,
  input  logic                  io_din_v,
  output logic                  io_din_r,
  output logic [DATA_WIDTH-1:0] io_dout,
  output logic [NUM_OUT-1:0]    io_dout_v,
  input  logic [NUM_OUT-1:0]    io_dout_r
);

  logic [NUM_OUT-1:0] ok;
  lane_mask_t         okPad;
  logic               fire;

  // Unused upper lanes read as complete so the reduction covers only real lanes.
  always_comb begin
    okPad              = '1;
    okPad[NUM_OUT-1:0] = ok;
  end

  // Ready is built from ok alone and never from io_din_v, avoiding a loop through the FIFO.
  assign io_din_r = &okPad;
  assign fire     = io_din_v & io_din_r;
  assign io_dout  = io_din;

  for (genvar i = 0; i < NUM_OUT; i++) begin : gLane
    d_fork_lane uLane (
      .clock    (clock),
      .reset    (reset),
      .mask_i   (io_mask[i]),
      .din_v    (io_din_v),
      .dout_r_i (io_dout_r[i]),
      .fire     (fire),
      .dout_v_i (io_dout_v[i]),
      .ok_i     (ok[i])
    );
  end

endmodule : d_eager_fork

// File: tb/tb_d_eager_fork.sv
// Self-checking bench for d_eager_fork: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a served-set model of the fork.
module tb_d_eager_fork;

  localparam int DW = 32;
  localparam int N  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  io_mask;
  logic [DW-1:0] io_din;
  logic          io_din_v;
  logic          io_din_r;
  logic [DW-1:0] io_dout;
  logic [N-1:0]  io_dout_v;
  logic [N-1:0]  io_dout_r;

  int compared   = 0;
  int mismatched = 0;

  // Model: which lanes already hold the current token, and how often each lane took it.
  bit served[N];
  int deliv[N];
  bit tokenDirty;

  always #5 clock = ~clock;

  d_eager_fork #(.DATA_WIDTH(DW), .NUM_OUT(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .io_mask   (io_mask),
    .io_din    (io_din),
    .io_din_v  (io_din_v),
    .io_din_r  (io_din_r),
    .io_dout   (io_dout),
    .io_dout_v (io_dout_v),
    .io_dout_r (io_dout_r)
  );

  // A lane is offered the token if it is enabled and has not taken it yet.
  function automatic logic [N-1:0] modelValid();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = io_din_v && io_mask[i] && !served[i];
    return v;
  endfunction

  // The token can leave once every enabled lane has it or is taking it now.
  function automatic logic modelReady();
    int missing;
    missing = 0;
    for (int i = 0; i < N; i++)
      if (io_mask[i] && !served[i] && !io_dout_r[i]) missing++;
    return (missing == 0);
  endfunction

  task automatic checkOne(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("dout_v", 64'(io_dout_v), 64'(modelValid()));
    checkOne("din_r", 64'(io_din_r), 64'(modelReady()));
    checkOne("dout_payload", 64'(io_dout), 64'(io_din));
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] m, input logic v,
                               input logic [DW-1:0] d, input logic [N-1:0] r);
    @(negedge clock);
    reset     = rst;
    io_mask   = m;
    io_din_v  = v;
    io_din    = d;
    io_dout_r = r;
    #1;
    checkOutput();
  endtask

  // Model advance on each clock edge, plus the exactly-once delivery check at token release.
  always @(posedge clock) begin : modelUpdate
    logic [N-1:0] v;
    logic         r;
    v = modelValid();
    r = modelReady();
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        served[i] = 1'b0;
        deliv[i]  = 0;
      end
      tokenDirty = 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (v[i] && io_dout_r[i]) deliv[i]++;
      if (io_din_v && r) begin
        if (!tokenDirty)
          for (int i = 0; i < N; i++)
            if (io_mask[i]) checkOne($sformatf("deliv_once_lane%0d", i), 64'(deliv[i]), 64'd1);
        for (int i = 0; i < N; i++) begin
          served[i] = 1'b0;
          deliv[i]  = 0;
        end
        tokenDirty = 1'b0;
      end else begin
        for (int i = 0; i < N; i++)
          if (v[i] && io_dout_r[i]) served[i] = 1'b1;
      end
    end
  end

  initial begin : stimulus
    logic [DW-1:0] curD;
    logic          curV;
    logic [N-1:0]  curM;
    logic [N-1:0]  curR;
    logic          rst;
    logic          lastR;
    int            drained;

    reset      = 1'b1;
    io_mask    = '0;
    io_din_v   = 1'b0;
    io_din     = '0;
    io_dout_r  = '0;
    tokenDirty = 1'b0;
    for (int i = 0; i < N; i++) begin
      served[i] = 1'b0;
      deliv[i]  = 0;
    end

    applyStimulus(1'b1, 4'b0000, 1'b0, 32'h0, 4'b0000);
    checkOne("reset_dout_v", 64'(io_dout_v), 64'h0);

    // Full broadcast in one cycle.
    applyStimulus(1'b0, 4'b1111, 1'b1, 32'hDEADBEEF, 4'b1111);
    checkOne("t1_dout_v", 64'(io_dout_v), 64'hF);
    checkOne("t1_din_r", 64'(io_din_r), 64'h1);
    checkOne("t1_dout", 64'(io_dout), 64'hDEADBEEF);

    // Lanes accept in different cycles.
    applyStimulus(1'b0, 4'b1111, 1'b1, 32'h11111111, 4'b0001);
    checkOne("t2_c0_dout_v", 64'(io_dout_v), 64'hF);
    checkOne("t2_c0_din_r", 64'(io_din_r), 64'h0);
    applyStimulus(1'b0, 4'b1111, 1'b1, 32'h11111111, 4'b0100);
    checkOne("t2_c1_dout_v", 64'(io_dout_v), 64'hE);
    checkOne("t2_c1_din_r", 64'(io_din_r), 64'h0);
    applyStimulus(1'b0, 4'b1111, 1'b1, 32'h11111111, 4'b1010);
    checkOne("t2_c2_dout_v", 64'(io_dout_v), 64'hA);
    checkOne("t2_c2_din_r", 64'(io_din_r), 64'h1);

    // Only disabled lanes ready: the token stalls.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'b0101, 1'b1, 32'h22222222, 4'b1010);
      checkOne("t3_stall_dout_v", 64'(io_dout_v), 64'h5);
      checkOne("t3_stall_din_r", 64'(io_din_r), 64'h0);
    end
    applyStimulus(1'b0, 4'b0101, 1'b1, 32'h22222222, 4'b0101);
    checkOne("t3_release_din_r", 64'(io_din_r), 64'h1);

    // Sink mode drains everything.
    drained = 0;
    for (int t = 1; t <= 8; t++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, DW'(t), 4'b0000);
      checkOne("t4_sink_dout_v", 64'(io_dout_v), 64'h0);
      if (io_din_r) drained++;
    end
    checkOne("t4_sink_drained", 64'(drained), 64'd8);

    // Reset mid-token re-offers the token to all lanes.
    applyStimulus(1'b0, 4'b1111, 1'b1, 32'hCAFE0001, 4'b0011);
    checkOne("t5_partial_din_r", 64'(io_din_r), 64'h0);
    applyStimulus(1'b0, 4'b1111, 1'b1, 32'hCAFE0001, 4'b0000);
    checkOne("t5_served_dout_v", 64'(io_dout_v), 64'hC);
    applyStimulus(1'b1, 4'b1111, 1'b1, 32'hCAFE0001, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 1'b1, 32'hCAFE0001, 4'b0000);
    checkOne("t5_reoffer_dout_v", 64'(io_dout_v), 64'hF);
    checkOne("t5_reoffer_dout", 64'(io_dout), 64'hCAFE0001);

    // Masking out the stragglers completes the token at once.
    applyStimulus(1'b1, 4'b1111, 1'b0, 32'h0, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 1'b1, 32'h33333333, 4'b0001);
    checkOne("t6_part_din_r", 64'(io_din_r), 64'h0);
    tokenDirty = 1'b1;
    applyStimulus(1'b0, 4'b0001, 1'b1, 32'h33333333, 4'b0000);
    checkOne("t6_masked_din_r", 64'(io_din_r), 64'h1);
    tokenDirty = 1'b1;
    applyStimulus(1'b0, 4'b1111, 1'b1, 32'h44444444, 4'b0000);
    checkOne("t6_cleared_dout_v", 64'(io_dout_v), 64'hF);

    // Randomized traffic; payload and valid stay stable while a token is pending.
    applyStimulus(1'b1, 4'b1111, 1'b0, 32'h0, 4'b0000);
    curM  = 4'b1111;
    curV  = 1'b0;
    curD  = '0;
    lastR = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!(curV && !lastR)) begin
        curV = ($urandom % 4) != 0;
        curD = $urandom;
      end
      rst = ($urandom % 150) == 0;
      if (($urandom % 40) == 0) begin
        curM       = N'($urandom);
        tokenDirty = 1'b1;
      end
      curR = (($urandom % 2) == 0) ? N'($urandom | $urandom) : N'($urandom & $urandom);
      applyStimulus(rst, curM, curV, curD, curR);
      lastR = io_din_r | rst;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_d_eager_fork

// File: doc/d_eager_fork.md
Name: d_eager_fork

Overview:
- Elastic eager fork placed directly downstream of the 32-bit dataflow FIFO in each CGRA cell.
- Takes one valid/ready token stream from the FIFO output and broadcasts it to up to NUM_OUT consumers (PE operand ports, neighbour links).
- Each consumer may accept the token in a different cycle. A per-lane "served" bit remembers who already has it.
- The upstream token is consumed only once every enabled lane has taken it. Lanes are enabled by a static configuration mask.

Parameters:
- DATA_WIDTH, 32, width of the token payload.
- NUM_OUT, 4, number of output lanes (legal range 1..8).

Ports:
- clock, input, 1, single clock domain.
- reset, input, 1, synchronous active-high reset.
- io_mask, input, NUM_OUT, lane enable from the cell config register. Bit i=1 means lane i must receive every token.
- io_din, input, DATA_WIDTH, token payload from the FIFO io_dout.
- io_din_v, input, 1, token valid from the FIFO io_dout_v.
- io_din_r, output, 1, token consumed this cycle; drives the FIFO io_dout_r.
- io_dout, output, DATA_WIDTH, payload shared by all lanes; equals io_din, no register.
- io_dout_v, output, NUM_OUT, per-lane valid.
- io_dout_r, input, NUM_OUT, per-lane ready from the consumers.

Behaviour:
- State: done[NUM_OUT], one register per lane. Reset value is all zeros. No other state.
- Lane i output: io_dout_v[i] = io_din_v & io_mask[i] & ~done[i].
- Lane i accept: acc[i] = io_dout_v[i] & io_dout_r[i].
- Lane i complete: ok[i] = ~io_mask[i] | done[i] | io_dout_r[i].
- io_din_r = AND over i of ok[i]. This is combinational from io_dout_r and io_mask. It must not depend on io_din_v, so there is no combinational loop with the FIFO.
- io_dout_v must never depend combinationally on io_dout_r.
- Token consumed: fire = io_din_v & io_din_r.
- Next state, in priority order:
  - reset: done <= 0.
  - fire: done <= 0, ready for the next token.
  - otherwise: done <= done | acc.
- Latency is 0 cycles, a pure pass-through. Throughput is 1 token/cycle when all enabled lanes hold ready high.
- Per-lane state machine, implicit in done[i]:
  - PENDING (done=0) -> SERVED when acc[i] & ~fire.
  - SERVED -> PENDING on fire.
  - PENDING with acc & fire stays PENDING, because the token completed in the same cycle.
- A lane is served exactly once per token. It never sees the same token twice and never sees a duplicate valid after done is set.
- io_mask = 0: io_din_r = 1 constantly. Tokens are drained and discarded (sink mode). All io_dout_v are 0.
- io_din_v = 0: all io_dout_v are 0 and done holds. done is all zeros here in legal operation.
- io_din and io_din_v must stay stable while io_din_v=1 and io_din_r=0. This is the FIFO's guarantee. The fork does not check it.
- io_mask changes mid-token are allowed and take effect in the same cycle:
  - A newly masked lane counts as served.
  - A newly unmasked lane with done=0 is offered the current token.
- Reset mid-token: done is cleared. The partially served token is re-offered to all enabled lanes if the FIFO still presents it. Consumers are reset together with the fork.
- All width arithmetic is bitwise. There are no counters.

Decomposition:
- Package d_fork_pkg: constants DATA_WIDTH_DEF=32, NUM_OUT_DEF=4, NUM_OUT_MAX=8.
- Package d_fork_pkg also holds the typedef lane_mask_t (logic [NUM_OUT_MAX-1:0]).
- Sub-module d_fork_lane, instantiated NUM_OUT times via generate:
  - Inputs: clock, reset, mask_i, din_v, dout_r_i, fire.
  - Outputs: dout_v_i, ok_i.
  - Holds one done flop.
- The top level does the ok AND-reduction, generates fire, and passes the payload through.

Test Plan:
- Reset, NUM_OUT=4, mask=4'b1111, din=0xDEADBEEF, din_v=1, dout_r=4'b1111 -> same cycle dout_v=4'b1111, din_r=1; the next token is presented the following cycle.
- mask=4'b1111, dout_r follows 4'b0001, 4'b0100, 4'b1010 in cycles 0-2 -> dout_v follows 1111, 1110, 1010; din_r=0,0,1; done=0001,0101,0000; each lane accepts exactly once.
- mask=4'b0101, dout_r=4'b1010 held -> din_r=0 and dout_v=0101 hold indefinitely. Then set dout_r=4'b0101 -> din_r=1 in that cycle.
- mask=0, 8 back-to-back tokens 0x1..0x8 -> din_r=1 every cycle, dout_v=0 throughout, all 8 tokens drained in 8 cycles.
- mask=4'b1111, lanes 0 and 1 served, then reset=1 for one cycle with din_v held -> done=0; the following cycle dout_v=4'b1111 with the same din value.
- mask change mid-token: done=4'b0001, lanes 1-3 not ready, then mask goes from 1111 to 0001 -> din_r=1 in that cycle, done=0 next cycle.
